// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial mantissa add/subtract sequencer.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-bit counter is still needed when WIDTH is 1.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial datapath.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_mantissa_addsub.sv
// Bit-serial mantissa add/subtract, LSB first, one bit per clock with a registered carry.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_mantissa_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
  logic             last_bit;

  fa_bit_cell u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
        if (in_valid) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = WIDTH'({fa_s, res_q} >> 1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow is carry-into-MSB xor carry-out-of-MSB, both visible in the last RUN cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_co;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = res_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_mantissa_addsub.sv
// Scoreboarded, table-driven bench for serial_mantissa_addsub at WIDTH=24.
module tb_serial_mantissa_addsub;

  localparam int WIDTH = 24;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t a;
    word_t b;
    logic  sub;
    word_t expSum;
    logic  expCout;
    logic  expOvf;
  } vec_t;
  typedef struct {
    word_t sum;
    logic  cout;
    logic  ovf;
  } exp_t;

  logic  clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  word_t a, b, sum;

  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;
  vec_t vecs[11];

  serial_mantissa_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input word_t va, input word_t vb, input logic vsub, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("in_ready before accept", in_ready, 1);
    a        = va;
    b        = vb;
    sub      = vsub;
    in_valid = 1'b1;
    scoreboard.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < WIDTH + 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkValue("out_valid wait", out_valid, 1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkValue({tag, " scoreboard nonempty"}, 0, 1);
    end else begin
      e = scoreboard.pop_front();
      checkValue({tag, " sum"}, sum, e.sum);
      checkValue({tag, " cout"}, cout, e.cout);
      checkValue({tag, " ovf"}, ovf, e.ovf);
    end
  endtask

  initial begin
    int   cyc;
    int   sawValid;
    exp_t e;

    vecs[0]  = '{24'h000001, 24'h000001, 1'b0, 24'h000002, 1'b0, 1'b0};
    vecs[1]  = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0};
    vecs[2]  = '{24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    vecs[3]  = '{24'h000007, 24'h000005, 1'b1, 24'h000002, 1'b1, 1'b0};
    vecs[4]  = '{24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1};
    vecs[5]  = '{24'h800000, 24'h000001, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
    vecs[6]  = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[7]  = '{24'h123456, 24'h123456, 1'b1, 24'h000000, 1'b1, 1'b0};
    vecs[8]  = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[9]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b1, 1'b0};
    vecs[10] = '{24'h400000, 24'h400000, 1'b0, 24'h800000, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    #12;
    checkValue("reset in_ready", in_ready, 1);
    checkValue("reset out_valid", out_valid, 0);
    checkValue("reset busy", busy, 0);
    checkValue("reset sum", sum, 0);
    checkValue("reset cout", cout, 0);
    checkValue("reset ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      e.sum  = vecs[i].expSum;
      e.cout = vecs[i].expCout;
      e.ovf  = OVF_EN ? vecs[i].expOvf : 1'b0;
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, e);
      checkValue($sformatf("vec%0d busy in RUN", i), busy, 1);
      waitResult(cyc);
      checkValue($sformatf("vec%0d latency", i), cyc, WIDTH);
      checkOutput($sformatf("vec%0d", i));
      @(posedge clk); #1;
      checkValue($sformatf("vec%0d in_ready after", i), in_ready, 1);
      checkValue($sformatf("vec%0d busy after", i), busy, 0);
      checkValue($sformatf("vec%0d out_valid after", i), out_valid, 0);
    end

    // Backpressure: hold DONE for 10 cycles and pulse an ignored in_valid.
    out_ready = 1'b0;
    e = '{24'h000579, 1'b0, 1'b0};
    applyStimulus(24'h000123, 24'h000456, 1'b0, e);
    waitResult(cyc);
    checkValue("bp latency", cyc, WIDTH);
    for (int k = 0; k < 10; k++) begin
      checkValue($sformatf("bp%0d out_valid", k), out_valid, 1);
      checkValue($sformatf("bp%0d sum", k), sum, 24'h000579);
      checkValue($sformatf("bp%0d cout", k), cout, 0);
      checkValue($sformatf("bp%0d in_ready", k), in_ready, 0);
      if (k == 3) begin
        a        = 24'hFFFFFF;
        b        = 24'hFFFFFF;
        in_valid = 1'b1;
      end
      if (k == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkValue("bp in_ready after", in_ready, 1);
    checkValue("bp busy after", busy, 0);
    checkValue("bp out_valid after", out_valid, 0);
    sawValid = 0;
    for (int k = 0; k < WIDTH + 5; k++) begin
      if (out_valid || busy) sawValid = 1;
      @(posedge clk); #1;
    end
    checkValue("bp ignored pulse", sawValid, 0);

    // Reset in the middle of RUN discards the operation.
    e = '{24'h000FFF, 1'b0, 1'b0};
    applyStimulus(24'h000AAA, 24'h000555, 1'b0, e);
    void'(scoreboard.pop_back());
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("midreset in_ready", in_ready, 1);
    checkValue("midreset out_valid", out_valid, 0);
    checkValue("midreset busy", busy, 0);
    checkValue("midreset sum", sum, 0);
    checkValue("midreset cout", cout, 0);
    checkValue("midreset ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkValue("postreset in_ready", in_ready, 1);
    sawValid = 0;
    for (int k = 0; k < WIDTH + 10; k++) begin
      if (out_valid) sawValid = 1;
      @(posedge clk); #1;
    end
    checkValue("aborted op no out_valid", sawValid, 0);

    e = '{24'h00BCDE, 1'b0, 1'b0};
    applyStimulus(24'h00ABCD, 24'h001111, 1'b0, e);
    waitResult(cyc);
    checkValue("fresh latency", cyc, WIDTH);
    checkOutput("fresh");
    @(posedge clk); #1;
    checkValue("fresh in_ready after", in_ready, 1);
    checkValue("scoreboard drained", scoreboard.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
